model_matrix_out_collector: RTL and testbench
=============================================

// Module: model_matrix_out_collector
// PURPOSE
// - Receiving end of the row/element streaming protocol the model controller uses on W_OUT/K_OUT/U_OUT/B_OUT/H_OUT.
// - Captures one SIZE_I x SIZE_J matrix, element by element, into an internal row-major buffer.
// - Pulses READY when the matrix is complete and exposes a registered random-access read port.
// - Sink for trainer outputs in benches and in the integrated NTM datapath.
// PARAMETERS
// - DATA_SIZE     64   element and size-bus width
// - CONTROL_SIZE  64   width of internal i/j counters
// - DEPTH         256  max stored elements; power of two; ADDR_SIZE = $clog2(DEPTH)
// PORTS
// - CLK             in   1          single clock, rising edge
// - RST             in   1          synchronous reset, active-high
// - START           in   1          begin capture; latches SIZE_I_IN/SIZE_J_IN
// - READY           out  1          one-cycle pulse: capture finished or aborted
// - ERROR           out  1          sticky protocol/size violation flag
// - SIZE_I_IN       in   DATA_SIZE  row count
// - SIZE_J_IN       in   DATA_SIZE  elements per row
// - DATA_I_ENABLE   in   1          row-start strobe from producer
// - DATA_J_ENABLE   in   1          element-valid strobe from producer
// - DATA_IN         in   DATA_SIZE  element value, sampled when DATA_J_ENABLE=1
// - RD_ENABLE       in   1          read request
// - RD_I            in   DATA_SIZE  read row index
// - RD_J            in   DATA_SIZE  read column index
// - RD_DATA         out  DATA_SIZE  read data, registered
// - RD_VALID        out  1          RD_DATA valid, one cycle after RD_ENABLE
// - CHECKSUM        out  DATA_SIZE  running element sum (see CONFIGURATION)
// BEHAVIOUR
// - Reset: READY=0, ERROR=0, RD_DATA=0, RD_VALID=0, CHECKSUM=0, state IDLE, i=j=0. Buffer contents not cleared.
// - FSM states: IDLE, WAIT_ROW, WAIT_ELEM, DONE.
// - IDLE + START: latch sizes, clear i/j and ERROR.
//   - If SIZE_I*SIZE_J == 0: go to DONE.
//   - If SIZE_I*SIZE_J > DEPTH: set ERROR, go to DONE.
//   - Otherwise go to WAIT_ROW.
// - WAIT_ROW:
//   - DATA_I_ENABLE=1 -> WAIT_ELEM. If DATA_J_ENABLE=1 in the same cycle, that element is also captured.
//   - DATA_J_ENABLE=1 alone -> ERROR=1, element dropped, state held.
// - WAIT_ELEM:
//   - DATA_J_ENABLE=1: write DATA_IN at address i*SIZE_J+j.
//     - If j==SIZE_J-1: j=0. If i==SIZE_I-1 -> DONE, else i++ and -> WAIT_ROW.
//     - Otherwise j++.
//   - DATA_I_ENABLE=1 with j!=0 (premature row): ERROR=1, strobe ignored.
// - DONE: READY=1 for exactly one cycle, then IDLE. Latency: READY is asserted the cycle after the last element is captured.
// - START outside IDLE: restart. Counters cleared, sizes re-latched, ERROR cleared; partially written data is not erased.
// - RST mid-capture: immediate return to IDLE; READY is not pulsed.
// - Read port: usable in any state.
//   - RD_VALID/RD_DATA appear 1 cycle after RD_ENABLE.
//   - Address = RD_I*SIZE_J + RD_J, using the latched SIZE_J.
//   - Out of range (RD_I>=SIZE_I or RD_J>=SIZE_J) returns 0.
//   - Same-cycle write and read to one address returns the old data.
// - Address arithmetic is truncated to ADDR_SIZE only after the range check.
// CONFIGURATION
// - MODEL_COLLECTOR_CHECKSUM_EN defined:
//   - CHECKSUM = modulo-2^DATA_SIZE sum of every captured element; cleared on START.
//   - Final value is stable from the READY pulse until the next START.
// - MODEL_COLLECTOR_CHECKSUM_EN undefined: CHECKSUM tied to 0, no adder. Port list unchanged.
// TESTING
// - 2x3 capture, I_EN before each row, elements 1..6 -> READY one cycle after 6th J_EN; read (1,2)=6, (0,0)=1, ERROR=0.
// - I_EN and J_EN same cycle on every row start, 3x2 values 10..15 -> all six stored; read (2,0)=14.
// - SIZE_I=20, SIZE_J=20 (400>256) -> ERROR=1 and READY pulse 2 cycles after START; no buffer writes.
// - J_EN in WAIT_ROW with no I_EN -> ERROR=1, element dropped; continued valid stream still completes with READY.
// - RST asserted after 3 of 6 elements -> READY stays 0, all outputs return to reset values; new START 2x2 completes normally.
// - CHECKSUM_EN build, 2x2 elements 0xFFFF_FFFF_FFFF_FFFF,1,2,3 -> CHECKSUM=5 at READY; read (5,0) -> RD_DATA=0, RD_VALID=1.

Source files
------------

// File: rtl/model_matrix_out_collector.sv
// model_matrix_out_collector
//
// Receiving end of the row/element streaming protocol used by the model
// controller. One SIZE_I x SIZE_J matrix is captured element by element into a
// row-major buffer. READY pulses once the matrix is complete (or the request
// is rejected). A registered random-access read port works in every state.
//
// Optional feature: define MODEL_COLLECTOR_CHECKSUM_EN to build a running
// modulo-2^DATA_SIZE sum of captured elements on CHECKSUM. Without it,
// CHECKSUM is tied to zero and no adder is built.
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   START             begin capture, latches SIZE_I_IN / SIZE_J_IN
//   READY             one-cycle pulse: capture finished or rejected
//   ERROR             sticky protocol/size violation, cleared by START
//   SIZE_I_IN         row count
//   SIZE_J_IN         elements per row
//   DATA_I_ENABLE     row-start strobe
//   DATA_J_ENABLE     element-valid strobe, DATA_IN sampled with it
//   RD_ENABLE         read request for element (RD_I, RD_J)
//   RD_DATA/RD_VALID  read result, one cycle after RD_ENABLE
//   CHECKSUM          running element sum (zero unless feature enabled)
module model_matrix_out_collector #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int DEPTH        = 256
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic                 DATA_I_ENABLE,
  input  logic                 DATA_J_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  input  logic                 RD_ENABLE,
  input  logic [DATA_SIZE-1:0] RD_I,
  input  logic [DATA_SIZE-1:0] RD_J,
  output logic [DATA_SIZE-1:0] RD_DATA,
  output logic                 RD_VALID,
  output logic [DATA_SIZE-1:0] CHECKSUM
);

  localparam int ADDR_SIZE = $clog2(DEPTH);
  localparam int PROD_W    = 2 * DATA_SIZE;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ROW  = 2'd1;
  localparam logic [1:0] WAIT_ELEM = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]              state_q;
  logic [DATA_SIZE-1:0]    size_i_q;
  logic [DATA_SIZE-1:0]    size_j_q;
  logic [CONTROL_SIZE-1:0] i_q;
  logic [CONTROL_SIZE-1:0] j_q;
  logic                    error_q;
  logic                    ready_q;

  logic [PROD_W-1:0]       size_prod;
  logic                    size_zero;
  logic                    size_over;
  logic [DATA_SIZE-1:0]    i_ext;
  logic [DATA_SIZE-1:0]    j_ext;
  logic                    row_end;
  logic                    last_row;
  logic                    cap;
  logic [ADDR_SIZE-1:0]    wr_addr;
  logic [ADDR_SIZE-1:0]    rd_addr;
  logic                    rd_in_range;

  logic [DATA_SIZE-1:0]    mem [DEPTH];

  // Row-major flat index, computed modulo 2^ADDR_SIZE. Callers only rely on
  // it after the indices were range-checked, so the wrap never bites.
  function automatic logic [ADDR_SIZE-1:0] flat_addr(
    input logic [ADDR_SIZE-1:0] row,
    input logic [ADDR_SIZE-1:0] col,
    input logic [ADDR_SIZE-1:0] row_len
  );
    return row * row_len + col;
  endfunction

  // Product is formed at double width so huge sizes cannot wrap into range.
  assign size_prod = PROD_W'(SIZE_I_IN) * PROD_W'(SIZE_J_IN);
  assign size_zero = (size_prod == '0);
  assign size_over = (size_prod > PROD_W'(DEPTH));

  assign i_ext    = DATA_SIZE'(i_q);
  assign j_ext    = DATA_SIZE'(j_q);
  assign row_end  = (j_ext == size_j_q - DATA_SIZE'(1));
  assign last_row = (i_ext == size_i_q - DATA_SIZE'(1));

  // An element is taken in WAIT_ELEM, or in WAIT_ROW when the row-start strobe
  // arrives together with the first element. START/RST take priority.
  assign cap = !RST && !START && DATA_J_ENABLE &&
               ((state_q == WAIT_ELEM) || (state_q == WAIT_ROW && DATA_I_ENABLE));

  assign wr_addr = flat_addr(i_ext[ADDR_SIZE-1:0], j_ext[ADDR_SIZE-1:0],
                             size_j_q[ADDR_SIZE-1:0]);

  assign rd_in_range = (RD_I < size_i_q) && (RD_J < size_j_q);
  assign rd_addr     = flat_addr(RD_I[ADDR_SIZE-1:0], RD_J[ADDR_SIZE-1:0],
                                 size_j_q[ADDR_SIZE-1:0]);

  // Capture control
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      size_i_q <= '0;
      size_j_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      error_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (START) begin
        // START restarts from any state; already written data stays.
        size_i_q <= SIZE_I_IN;
        size_j_q <= SIZE_J_IN;
        i_q      <= '0;
        j_q      <= '0;
        error_q  <= size_over;
        state_q  <= (size_zero || size_over) ? DONE : WAIT_ROW;
      end else begin
        case (state_q)
          IDLE: begin
          end
          WAIT_ROW: begin
            if (DATA_I_ENABLE) begin
              state_q <= WAIT_ELEM;
            end else if (DATA_J_ENABLE) begin
              error_q <= 1'b1;
            end
          end
          WAIT_ELEM: begin
            if (DATA_I_ENABLE && (j_q != '0)) begin
              error_q <= 1'b1;
            end
          end
          DONE: begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase

        // Counter advance overrides the state chosen above when a row closes.
        if (cap) begin
          if (row_end) begin
            j_q <= '0;
            if (last_row) begin
              state_q <= DONE;
            end else begin
              i_q     <= i_q + CONTROL_SIZE'(1);
              state_q <= WAIT_ROW;
            end
          end else begin
            j_q <= j_q + CONTROL_SIZE'(1);
          end
        end
      end
    end
  end

  assign READY = ready_q;
  assign ERROR = error_q;

  // Buffer write stage
  always_ff @(posedge CLK) begin
    if (cap) begin
      mem[wr_addr] <= DATA_IN;
    end
  end

  // Read stage: same-edge write and read of one address returns the old word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      RD_VALID <= RD_ENABLE;
      if (RD_ENABLE) begin
        RD_DATA <= rd_in_range ? mem[rd_addr] : '0;
      end
    end
  end

`ifdef MODEL_COLLECTOR_CHECKSUM_EN
  logic [DATA_SIZE-1:0] checksum_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      checksum_q <= '0;
    end else if (START) begin
      checksum_q <= '0;
    end else if (cap) begin
      checksum_q <= checksum_q + DATA_IN;
    end
  end

  assign CHECKSUM = checksum_q;
`else
  assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_model_matrix_out_collector.sv
// Testbench for model_matrix_out_collector: directed scenarios plus randomized
// captures, checked every cycle against a flat-index behavioural model.
module tb_model_matrix_out_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic        error;
  logic [63:0] size_i;
  logic [63:0] size_j;
  logic        i_en;
  logic        j_en;
  logic [63:0] din;
  logic        rd_en;
  logic [63:0] rd_i;
  logic [63:0] rd_j;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [63:0] checksum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  model_matrix_out_collector dut (
    .CLK          (clk),
    .RST          (rst),
    .START        (start),
    .READY        (ready),
    .ERROR        (error),
    .SIZE_I_IN    (size_i),
    .SIZE_J_IN    (size_j),
    .DATA_I_ENABLE(i_en),
    .DATA_J_ENABLE(j_en),
    .DATA_IN      (din),
    .RD_ENABLE    (rd_en),
    .RD_I         (rd_i),
    .RD_J         (rd_j),
    .RD_DATA      (rd_data),
    .RD_VALID     (rd_valid),
    .CHECKSUM     (checksum)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, want 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The matrix is tracked as a flat element count k; a row must be opened by a
  // row-start strobe whenever k is a multiple of the row length.
  logic [63:0] m_mem [256];
  bit          m_wr  [256];
  logic [63:0] m_si = '0, m_sj = '0, m_k = '0, m_total = '0, m_sum = '0;
  logic [63:0] e_rd = '0, e_sum = '0;
  bit m_active, m_row_open, m_finish, m_err, m_seen_rst, m_sz_ok;
  bit e_ready, e_rv, e_rd_known;

  task automatic model_capture(input logic [63:0] v);
    m_mem[int'(m_k % 256)] = v;
    m_wr[int'(m_k % 256)]  = 1'b1;
    m_sum = m_sum + v;
    m_k   = m_k + 1;
    if (m_k % m_sj == 0) begin
      m_row_open = 1'b0;
      if (m_k == m_total) begin
        m_active = 1'b0;
        m_finish = 1'b1;
      end
    end else begin
      m_row_open = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [127:0] p;
    int a;
    e_ready = 1'b0;
    if (rst) begin
      m_seen_rst = 1'b1;
      m_active = 1'b0; m_row_open = 1'b0; m_finish = 1'b0; m_err = 1'b0;
      m_sum = '0; m_k = '0; m_sz_ok = 1'b0;
      e_rv = 1'b0; e_rd = '0; e_rd_known = 1'b1;
    end else begin
      if (rd_en) begin
        e_rv = 1'b1;
        if (!m_sz_ok) begin
          e_rd_known = 1'b0;
        end else if (rd_i < m_si && rd_j < m_sj) begin
          a = int'((rd_i * m_sj + rd_j) % 256);
          e_rd = m_mem[a];
          e_rd_known = m_wr[a];
        end else begin
          e_rd = '0;
          e_rd_known = 1'b1;
        end
      end else begin
        e_rv = 1'b0;
      end

      if (start) begin
        m_si = size_i; m_sj = size_j; m_sz_ok = 1'b1;
        m_k = '0; m_row_open = 1'b0; m_sum = '0;
        p = {64'd0, size_i} * {64'd0, size_j};
        if (p == 0 || p > 256) begin
          m_err = (p > 256);
          m_active = 1'b0;
          m_finish = 1'b1;
        end else begin
          m_err = 1'b0;
          m_active = 1'b1;
          m_finish = 1'b0;
          m_total = p[63:0];
        end
      end else if (m_finish) begin
        e_ready = 1'b1;
        m_finish = 1'b0;
      end else if (m_active) begin
        if (i_en && m_row_open && (m_k % m_sj) != 0) m_err = 1'b1;
        if (j_en) begin
          if (m_row_open || i_en) model_capture(din);
          else m_err = 1'b1;
        end else if (i_en && !m_row_open) begin
          m_row_open = 1'b1;
        end
      end
    end
`ifdef MODEL_COLLECTOR_CHECKSUM_EN
    e_sum = m_sum;
`else
    e_sum = '0;
`endif
  endtask

  // Single compare process: model advances on each edge, DUT checked 1 ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    if (m_seen_rst) begin
      chk("ready", {63'd0, ready}, {63'd0, e_ready});
      chk("error", {63'd0, error}, {63'd0, m_err});
      chk("rd_valid", {63'd0, rd_valid}, {63'd0, e_rv});
      if (e_rd_known) chk("rd_data", rd_data, e_rd);
      chk("checksum", checksum, e_sum);
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] vals[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_all();
    start = 1'b0; i_en = 1'b0; j_en = 1'b0; rd_en = 1'b0;
    din = '0; rd_i = '0; rd_j = '0;
  endtask

  task automatic rd_rand(input bit en, input int si, input int sj);
    if (en && $urandom_range(0, 1) == 1) begin
      rd_en = 1'b1;
      rd_i  = 64'($urandom_range(0, si));
      rd_j  = 64'($urandom_range(0, sj));
    end else begin
      rd_en = 1'b0;
    end
  endtask

  task automatic do_read(input int ri, input int rj);
    rd_en = 1'b1; rd_i = 64'(ri); rd_j = 64'(rj);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic fill_seq(input int first, input int n);
    vals.delete();
    for (int k = 0; k < n; k++) vals.push_back(64'(first + k));
  endtask

  // merge: 0 = separate row strobe, 1 = row strobe with first element, 2 = random
  task automatic run_capture(input int si, input int sj, input int merge,
                             input int gap, input bit rrd);
    start = 1'b1; size_i = 64'(si); size_j = 64'(sj); i_en = 1'b0; j_en = 1'b0;
    rd_rand(rrd, si, sj);
    tick();
    start = 1'b0;
    for (int r = 0; r < si; r++) begin
      bit mg;
      mg = (merge == 1) || (merge == 2 && $urandom_range(0, 1) == 1);
      if (!mg) begin
        i_en = 1'b1; j_en = 1'b0; rd_rand(rrd, si, sj);
        tick();
      end
      for (int c = 0; c < sj; c++) begin
        for (int g = 0; g < 3 && $urandom_range(0, 99) < gap; g++) begin
          i_en = 1'b0; j_en = 1'b0; rd_rand(rrd, si, sj);
          tick();
        end
        i_en = (c == 0) && mg; j_en = 1'b1; din = vals[r * sj + c];
        rd_rand(rrd, si, sj);
        tick();
      end
    end
    i_en = 1'b0; j_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    idle_all();
    size_i = '0; size_j = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_error", {63'd0, error}, 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_checksum", checksum, 64'd0);

    // 2x3, separate row strobes, 1..6
    fill_seq(1, 6);
    run_capture(2, 3, 0, 0, 1'b0);
    chk("s1_ready_early", {63'd0, ready}, 64'd0);
    tick();
    chk("s1_ready", {63'd0, ready}, 64'd1);
    chk("s1_error", {63'd0, error}, 64'd0);
    tick();
    chk("s1_ready_drop", {63'd0, ready}, 64'd0);
    chk("s1_model_mem5", m_mem[5], 64'd6);
    chk("s1_model_k", m_k, 64'd6);
    do_read(1, 2);
    chk("s1_rd_1_2", rd_data, 64'd6);
    chk("s1_rd_valid", {63'd0, rd_valid}, 64'd1);
    do_read(0, 0);
    chk("s1_rd_0_0", rd_data, 64'd1);

    // 3x2, row strobe merged with first element, 10..15
    fill_seq(10, 6);
    run_capture(3, 2, 1, 0, 1'b0);
    tick(); tick();
    chk("s2_model_mem4", m_mem[4], 64'd14);
    do_read(2, 0);
    chk("s2_rd_2_0", rd_data, 64'd14);

    // 20x20 exceeds the buffer
    start = 1'b1; size_i = 64'd20; size_j = 64'd20;
    tick();
    start = 1'b0;
    chk("s3_ready_early", {63'd0, ready}, 64'd0);
    chk("s3_error", {63'd0, error}, 64'd1);
    tick();
    chk("s3_ready", {63'd0, ready}, 64'd1);
    j_en = 1'b1; din = 64'd99;
    tick(); tick();
    j_en = 1'b0;
    // re-latch 3x2 and confirm earlier data survived the rejected request
    start = 1'b1; size_i = 64'd3; size_j = 64'd2;
    tick();
    start = 1'b0;
    do_read(2, 0);
    chk("s3_buffer_kept", rd_data, 64'd14);

    // stray element before row start, then a valid 2x2 stream
    start = 1'b1; size_i = 64'd2; size_j = 64'd2;
    tick();
    start = 1'b0;
    j_en = 1'b1; din = 64'd77;
    tick();
    j_en = 1'b0;
    chk("s4_error_set", {63'd0, error}, 64'd1);
    i_en = 1'b1; tick(); i_en = 1'b0;
    j_en = 1'b1; din = 64'd21; tick();
    din = 64'd22; tick();
    j_en = 1'b0; i_en = 1'b1; tick();
    i_en = 1'b0; j_en = 1'b1; din = 64'd23; tick();
    din = 64'd24; tick();
    j_en = 1'b0;
    tick();
    chk("s4_ready", {63'd0, ready}, 64'd1);
    chk("s4_error_sticky", {63'd0, error}, 64'd1);
    do_read(0, 0);
    chk("s4_rd_0_0", rd_data, 64'd21);
    do_read(1, 1);
    chk("s4_rd_1_1", rd_data, 64'd24);

    // reset after 3 of 6 elements
    start = 1'b1; size_i = 64'd2; size_j = 64'd3;
    tick();
    start = 1'b0;
    i_en = 1'b1; tick(); i_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      j_en = 1'b1; din = 64'(31 + k); rd_en = 1'b1; rd_i = '0; rd_j = '0;
      tick();
    end
    j_en = 1'b0; rd_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_ready", {63'd0, ready}, 64'd0);
    chk("s5_error", {63'd0, error}, 64'd0);
    chk("s5_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("s5_rd_data", rd_data, 64'd0);
    chk("s5_checksum", checksum, 64'd0);
    fill_seq(41, 4);
    run_capture(2, 2, 2, 0, 1'b1);
    tick(); tick();
    do_read(1, 1);
    chk("s5_rd_1_1", rd_data, 64'd44);

    // checksum wrap, out-of-range read
    vals.delete();
    vals.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    vals.push_back(64'd1); vals.push_back(64'd2); vals.push_back(64'd3);
    run_capture(2, 2, 0, 0, 1'b0);
    tick();
    chk("s6_ready", {63'd0, ready}, 64'd1);
    chk("s6_model_sum", m_sum, 64'd5);
`ifdef MODEL_COLLECTOR_CHECKSUM_EN
    chk("s6_checksum", checksum, 64'd5);
`else
    chk("s6_checksum", checksum, 64'd0);
`endif
    do_read(5, 0);
    chk("s6_rd_oob", rd_data, 64'd0);
    chk("s6_rd_oob_valid", {63'd0, rd_valid}, 64'd1);

    // randomized captures, including empty and oversized requests
    for (int it = 0; it < 40; it++) begin
      int si, sj;
      si = int'($urandom_range(0, 6));
      sj = int'($urandom_range(0, 6));
      if (it % 13 == 12) begin si = 17; sj = 16; end
      vals.delete();
      for (int k = 0; k < si * sj; k++) vals.push_back({$urandom, $urandom});
      run_capture(si, sj, 2, 30, 1'b1);
      for (int k = 0; k < 3; k++) begin
        rd_rand(1'b1, si, sj);
        tick();
      end
      rd_en = 1'b0;
    end

    idle_all();
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
